// File: rtl/reg_pipe_n_pkg.sv
// Shared defaults and elaboration helpers for the reg_pipe_n elastic pipeline.
package reg_pipe_n_pkg;

  localparam int DEFAULT_WIDTH = 100;
  localparam int DEFAULT_DEPTH = 2;

  // Smallest w such that 2**w >= n; sizes the occupancy counter.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_pipe_n_pipe_stage.sv
// One pipeline stage: a valid flop plus a payload register that only loads real data.
module pipe_stage
  import reg_pipe_n_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Clear squashes only the valid bit; payload is left in place to save toggles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= 1'b0;
      d <= '0;
    end else if (clear) begin
      v <= 1'b0;
    end else if (load) begin
      v <= src_v;
      if (src_v) d <= src_d;
    end
  end

endmodule

// File: rtl/reg_pipe_n.sv
// Elastic WIDTH x DEPTH pipeline register with per-stage valid, global hold and flush.
module reg_pipe_n
  import reg_pipe_n_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wE,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  // Handshake: a word moves across a port on a rising edge only when valid and
  // ready are both high in that cycle; valid never depends on ready at either port.

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH:0]   r;
  logic             clear;
  logic [CNT_W-1:0] cnt_nxt;

  // A stage can take a new word if it is empty or its occupant is moving on.
  always_comb begin
    r        = '0;
    r[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r[i] = ~v[i] | r[i+1];
    end
  end

  assign clear = wE & flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src_v[i] = in_valid;
      assign src_d[i] = in_data;
    end else begin : g_body
      assign src_v[i] = v[i-1];
      assign src_d[i] = d[i-1];
    end

    assign load[i]  = wE & ~flush & r[i];
    assign v_nxt[i] = clear ? 1'b0 : (load[i] ? src_v[i] : v[i]);

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .reset (reset),
      .load  (load[i]),
      .clear (clear),
      .src_v (src_v[i]),
      .src_d (src_d[i]),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  // Occupancy is registered from the next-state valids so it tracks v edge for edge.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= cnt_nxt;
  end

  assign in_ready  = wE & r[0] & reset;
  assign out_valid = wE & v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe_n.sv
// Directed bench for reg_pipe_n: DEPTH=3 main instance plus a DEPTH=1 instance.
module tb_reg_pipe_n;

  localparam int W = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic         wE;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  logic         flush1;
  logic         in_valid1;
  logic         in_ready1;
  logic [W-1:0] in_data1;
  logic         out_valid1;
  logic         out_ready1;
  logic [W-1:0] out_data1;
  logic [0:0]   count1;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];

  reg_pipe_n #(.WIDTH(W), .DEPTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .wE        (wE),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  reg_pipe_n #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .wE        (wE),
    .flush     (flush1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .count     (count1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pop on every output transfer, push on every accepted input
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out got=%0h exp=none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
    if (reset && in_valid && in_ready && !flush) exp_q.push_back(in_data);
    if (reset && wE && flush) exp_q.delete();

    if (reset && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out1 got=%0h exp=none", out_data1);
      end else begin
        check("out_data1", out_data1, exp1_q.pop_front());
      end
    end
    if (reset && in_valid1 && in_ready1) exp1_q.push_back(in_data1);
  end

  // drain the DEPTH=3 pipe for n cycles with idle input, checking count decay
  task automatic drain(input string tag, input int start_cnt);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_drain_count"}, W'(count), W'((start_cnt - j) > 0 ? (start_cnt - j) : 0));
    end
    check({tag, "_q_empty"}, W'(exp_q.size()), W'(0));
  endtask

  initial begin
    int w;
    reset      = 1'b0;
    wE         = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush1     = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = '0;
    out_ready1 = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_count", W'(count), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_out_valid1", W'(out_valid1), W'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", W'(in_ready), W'(1));
    check("rel_count", W'(count), W'(0));

    // stream 1..8 back to back, latency 3, count saturates at 3
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'(k);
      @(negedge clk);
      check("s_count", W'(count), W'((k - 1) > 3 ? 3 : (k - 1)));
      check("s_out_valid", W'(out_valid), W'(k >= 4));
      check("s_in_ready", W'(in_ready), W'(1));
    end
    drain("s", 3);

    // backpressure: only 3 of 5 words fit while downstream stalls
    w = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'(w);
      @(negedge clk);
      check("bp_in_ready", W'(in_ready), W'(k <= 3));
      if (k <= 3) w++;
    end
    check("bp_full_count", W'(count), W'(3));
    check("bp_full_out_valid", W'(out_valid), W'(1));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'(w);
      @(negedge clk);
      check("bp_pass_in_ready", W'(in_ready), W'(1));
      check("bp_pass_count", W'(count), W'(3));
      w++;
    end
    drain("bp", 3);

    // flush with 2 words in flight and 0xAA offered
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'(17 * k);
      @(negedge clk);
    end
    @(posedge clk); #1;
    flush   = 1'b1;
    in_data = W'('hAA);
    @(negedge clk);
    check("fl_out_valid", W'(out_valid), W'(0));
    check("fl_count_before", W'(count), W'(2));
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_count_after", W'(count), W'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fl_no_out", W'(out_valid), W'(0));
    end
    check("fl_q_empty", W'(exp_q.size()), W'(0));

    // global hold mid-stream
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'('h31 + k);
      @(negedge clk);
    end
    for (int h = 0; h < 4; h++) begin
      @(posedge clk); #1;
      wE       = 1'b0;
      in_valid = 1'b1;
      in_data  = W'('h34);
      @(negedge clk);
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_out_valid", W'(out_valid), W'(0));
      check("hold_count", W'(count), W'(3));
    end
    for (int k = 3; k < 6; k++) begin
      @(posedge clk); #1;
      wE       = 1'b1;
      in_valid = 1'b1;
      in_data  = W'('h31 + k);
      @(negedge clk);
      check("resume_in_ready", W'(in_ready), W'(1));
      check("resume_out_valid", W'(out_valid), W'(1));
    end
    drain("hold", 3);

    // reset mid-stream with 2 words in flight
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'('h41 + k);
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    exp_q.delete();
    exp1_q.delete();
    #1;
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_count", W'(count), W'(0));
    check("mid_rst_in_ready", W'(in_ready), W'(0));
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_out_valid", W'(out_valid), W'(0));
      check("post_rst_count", W'(count), W'(0));
    end

    // DEPTH=1 with out_ready toggling
    w = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      out_ready1 = (k % 2) == 1;
      in_valid1  = 1'b1;
      in_data1   = W'('h60 + w);
      @(negedge clk);
      check("d1_in_ready", W'(in_ready1), W'((k % 2) == 1));
      check("d1_out_valid", W'(out_valid1), W'(k > 1));
      if ((k % 2) == 1) w++;
    end
    @(posedge clk); #1;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    @(negedge clk);
    check("d1_last_out_valid", W'(out_valid1), W'(1));
    @(negedge clk);
    check("d1_empty_out_valid", W'(out_valid1), W'(0));
    check("d1_q_empty", W'(exp1_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
